// File: rtl/rtc_bus_arbiter.sv
// rtc_bus_arbiter: round-robin owner selection among three requesters
// (chrono reset sequencer, time/config writer, periodic time reader) and
// the multiplexed address/data strobe sequence for an external RTC.
// Each transaction is IDLE -> ADDR -> GAP -> DATA -> DONE -> IDLE. Every
// output is a flop loaded from a value decoded from the next state, so
// the outputs change on the same edge as the state register.
module rtc_bus_arbiter #(
    parameter int PULSE_CYC = 8,
    parameter int GAP_CYC   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] req,
    input  logic [7:0] addr0,
    input  logic [7:0] addr1,
    input  logic [7:0] addr2,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    input  logic [7:0] wdata2,
    input  logic [2:0] we,
    output logic [2:0] grant,
    output logic [2:0] done,
    output logic [7:0] rdata,
    output logic       cs_n,
    output logic       ad_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic [7:0] bus_out,
    output logic       bus_oe,
    input  logic [7:0] bus_in
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_GAP  = 3'd2,
        S_DATA = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // The phase counter counts down to zero, so a phase of N cycles
    // is entered with N-1.
    localparam logic [7:0] PULSE_LOAD = 8'(PULSE_CYC - 1);
    localparam logic [7:0] GAP_LOAD   = 8'(GAP_CYC - 1);

    // State, shared phase counter and round-robin pointer
    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] last_q, last_d;
    logic [1:0] owner_q, owner_d;

    // Requester fields captured at grant time
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       we_q, we_d;

    // Registered outputs
    logic [2:0] grant_q, grant_d;
    logic [2:0] done_q, done_d;
    logic [7:0] rdata_q, rdata_d;
    logic       cs_n_q, cs_n_d;
    logic       ad_n_q, ad_n_d;
    logic       rd_n_q, rd_n_d;
    logic       wr_n_q, wr_n_d;
    logic [7:0] bus_out_q, bus_out_d;
    logic       bus_oe_q, bus_oe_d;

    // Requester index 0..2 to its one-hot grant/done pattern
    function automatic logic [2:0] onehot3(input logic [1:0] idx);
        logic [2:0] oh;
        oh = 3'b001 << idx;
        return oh;
    endfunction

    // Successor in the 0 -> 1 -> 2 -> 0 ring
    function automatic logic [1:0] ring_next(input logic [1:0] idx);
        logic [1:0] nxt;
        nxt = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
        return nxt;
    endfunction

    // Request bit for a requester index; index 3 never requests
    function automatic logic req_at(input logic [2:0] r, input logic [1:0] idx);
        logic bit_v;
        case (idx)
            2'd0:    bit_v = r[0];
            2'd1:    bit_v = r[1];
            2'd2:    bit_v = r[2];
            default: bit_v = 1'b0;
        endcase
        return bit_v;
    endfunction

    // First active requester found walking the ring from last+1;
    // only meaningful when at least one request bit is set.
    function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
        logic [1:0] idx;
        logic [1:0] win;
        logic       found;
        idx   = ring_next(last);
        win   = idx;
        found = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (!found && req_at(r, idx)) begin
                win   = idx;
                found = 1'b1;
            end
            idx = ring_next(idx);
        end
        return win;
    endfunction

    // Next-state, phase counter, capture registers and output decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        done_d  = 3'b000;

        case (state_q)
            S_IDLE: begin
                // Requester inputs are looked at only here; everything the
                // transaction needs is copied so later input changes are moot.
                if (req != 3'b000) begin
                    owner_d = rr_pick(req, last_q);
                    case (owner_d)
                        2'd0: begin
                            addr_d  = addr0;
                            wdata_d = wdata0;
                            we_d    = we[0];
                        end
                        2'd1: begin
                            addr_d  = addr1;
                            wdata_d = wdata1;
                            we_d    = we[1];
                        end
                        default: begin
                            addr_d  = addr2;
                            wdata_d = wdata2;
                            we_d    = we[2];
                        end
                    endcase
                    state_d = S_ADDR;
                    cnt_d   = PULSE_LOAD;
                end
            end
            S_ADDR: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_GAP: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_DATA;
                    cnt_d   = PULSE_LOAD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_DATA: begin
                if (cnt_q == 8'd0) begin
                    // Last strobe cycle: the RTC is still driving, capture now
                    if (!we_q) begin
                        rdata_d = bus_in;
                    end
                    done_d  = onehot3(owner_q);
                    last_d  = owner_q;
                    state_d = S_DONE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
            end
        endcase

        // Bus pins follow the state being entered so they settle on the
        // same edge as the state register.
        grant_d   = 3'b000;
        cs_n_d    = 1'b1;
        ad_n_d    = 1'b1;
        rd_n_d    = 1'b1;
        wr_n_d    = 1'b1;
        bus_oe_d  = 1'b0;
        bus_out_d = 8'h00;

        case (state_d)
            S_ADDR: begin
                grant_d   = onehot3(owner_d);
                cs_n_d    = 1'b0;
                ad_n_d    = 1'b0;
                wr_n_d    = 1'b0;
                bus_oe_d  = 1'b1;
                bus_out_d = addr_d;
            end
            S_GAP: begin
                grant_d = onehot3(owner_d);
                cs_n_d  = 1'b0;
            end
            S_DATA: begin
                grant_d = onehot3(owner_d);
                cs_n_d  = 1'b0;
                if (we_d) begin
                    wr_n_d    = 1'b0;
                    bus_oe_d  = 1'b1;
                    bus_out_d = wdata_d;
                end else begin
                    // Read: the bus is released so the RTC can drive it
                    rd_n_d = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

    // State register and all output flops; reset aborts any transaction
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 8'd0;
            last_q    <= 2'd2;
            owner_q   <= 2'd0;
            addr_q    <= 8'h00;
            wdata_q   <= 8'h00;
            we_q      <= 1'b0;
            grant_q   <= 3'b000;
            done_q    <= 3'b000;
            rdata_q   <= 8'h00;
            cs_n_q    <= 1'b1;
            ad_n_q    <= 1'b1;
            rd_n_q    <= 1'b1;
            wr_n_q    <= 1'b1;
            bus_out_q <= 8'h00;
            bus_oe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            rdata_q   <= rdata_d;
            cs_n_q    <= cs_n_d;
            ad_n_q    <= ad_n_d;
            rd_n_q    <= rd_n_d;
            wr_n_q    <= wr_n_d;
            bus_out_q <= bus_out_d;
            bus_oe_q  <= bus_oe_d;
        end
    end

    assign grant   = grant_q;
    assign done    = done_q;
    assign rdata   = rdata_q;
    assign cs_n    = cs_n_q;
    assign ad_n    = ad_n_q;
    assign rd_n    = rd_n_q;
    assign wr_n    = wr_n_q;
    assign bus_out = bus_out_q;
    assign bus_oe  = bus_oe_q;

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Testbench for rtc_bus_arbiter: directed transactions push their expected
// outcome into a queue; a monitor watches the RTC pins every falling edge,
// measures each transaction and compares it against the queue head at done.
module tb_rtc_bus_arbiter;

    localparam int P = 8;
    localparam int G = 4;

    logic       clk;
    logic       reset;
    logic [2:0] req;
    logic [7:0] addr0, addr1, addr2;
    logic [7:0] wdata0, wdata1, wdata2;
    logic [2:0] we;
    logic [2:0] grant;
    logic [2:0] done;
    logic [7:0] rdata;
    logic       cs_n, ad_n, rd_n, wr_n;
    logic [7:0] bus_out;
    logic       bus_oe;
    logic [7:0] bus_in;

    rtc_bus_arbiter #(.PULSE_CYC(P), .GAP_CYC(G)) dut (
        .clk(clk), .reset(reset), .req(req),
        .addr0(addr0), .addr1(addr1), .addr2(addr2),
        .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
        .we(we), .grant(grant), .done(done), .rdata(rdata),
        .cs_n(cs_n), .ad_n(ad_n), .rd_n(rd_n), .wr_n(wr_n),
        .bus_out(bus_out), .bus_oe(bus_oe), .bus_in(bus_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] oh;
        logic [7:0] addr;
        logic       wr;
        logic [7:0] data;
        logic       chk_idle;
    } exp_t;

    exp_t q[$];
    int n_chk  = 0;
    int n_pass = 0;
    int viol   = 0;

    task automatic chk(input string nm, input int act, input int exp_v);
        n_chk++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp_v);
    endtask

    task automatic push(input logic [2:0] oh, input logic [7:0] a, input logic w,
                        input logic [7:0] d, input logic ci);
        exp_t e;
        e.oh = oh; e.addr = a; e.wr = w; e.data = d; e.chk_idle = ci;
        q.push_back(e);
    endtask

    task automatic wait_done(input string nm);
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (done != 3'b000) seen = 1'b1;
        end
        chk(nm, int'(seen), 1);
    endtask

    // Monitor state
    bit         active = 1'b0;
    logic [2:0] g0;
    logic [2:0] prev_done = 3'b000;
    int cyc, ad_cnt, gap_cnt, dat_cnt, a_val, d_val, idle_cnt, start_idle;
    bit a_bad, d_bad, saw_wr, saw_rd;

    initial begin
        exp_t e;
        idle_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rd_n && !wr_n) viol++;
            if (!rd_n && bus_oe) viol++;
            if (done != 3'b000 && prev_done != 3'b000) viol++;
            if (done != 3'b000 && !$onehot(done)) viol++;
            prev_done = done;
            if (!active) begin
                if (grant != 3'b000) begin
                    active = 1'b1; g0 = grant; cyc = 0;
                    ad_cnt = 0; gap_cnt = 0; dat_cnt = 0; a_val = 0; d_val = 0;
                    a_bad = 1'b0; d_bad = 1'b0; saw_wr = 1'b0; saw_rd = 1'b0;
                    start_idle = idle_cnt;
                end else if (done == 3'b000) begin
                    idle_cnt++;
                end else begin
                    chk("unexpected_done", int'(done), 0);
                end
            end
            if (active) begin
                cyc++;
                if (grant == 3'b000 && done == 3'b000) begin
                    active = 1'b0;
                end else if (grant != 3'b000) begin
                    if (cs_n) viol++;
                    if (grant != g0) viol++;
                    if (!ad_n) begin
                        ad_cnt++;
                        if (!bus_oe) viol++;
                        if (ad_cnt == 1) a_val = int'(bus_out);
                        else if (int'(bus_out) != a_val) a_bad = 1'b1;
                    end else if (!wr_n) begin
                        dat_cnt++; saw_wr = 1'b1;
                        if (!bus_oe) viol++;
                        if (dat_cnt == 1) d_val = int'(bus_out);
                        else if (int'(bus_out) != d_val) d_bad = 1'b1;
                    end else if (!rd_n) begin
                        dat_cnt++; saw_rd = 1'b1;
                    end else begin
                        gap_cnt++;
                        if (bus_oe) viol++;
                    end
                end else begin
                    if (q.size() == 0) begin
                        chk("unexpected_done", int'(done), 0);
                    end else begin
                        e = q.pop_front();
                        chk("done_owner", int'(done), int'(e.oh));
                        chk("grant_owner", int'(g0), int'(e.oh));
                        chk("addr", a_bad ? 'h1FF : a_val, int'(e.addr));
                        chk("addr_cycles", ad_cnt, P);
                        chk("gap_cycles", gap_cnt, G);
                        chk("data_cycles", dat_cnt, P);
                        chk("latency", cyc - 1, 2 * P + G);
                        if (e.wr) begin
                            chk("wdata", d_bad ? 'h1FF : d_val, int'(e.data));
                            chk("write_strobe", int'(saw_wr && !saw_rd), 1);
                        end else begin
                            chk("rdata", int'(rdata), int'(e.data));
                            chk("read_strobe", int'(saw_rd && !saw_wr), 1);
                        end
                        if (e.chk_idle) chk("idle_gap", start_idle, 1);
                    end
                    active = 1'b0;
                    idle_cnt = 0;
                end
            end
        end
    end

    // Stimulus
    initial begin
        int  n;
        bit  found;
        reset = 1'b1; req = 3'b000; we = 3'b000; bus_in = 8'h00;
        addr0 = 8'h00; addr1 = 8'h00; addr2 = 8'h00;
        wdata0 = 8'h00; wdata1 = 8'h00; wdata2 = 8'h00;
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_grant", int'(grant), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_rdata", int'(rdata), 0);
        chk("rst_strobes", int'({cs_n, ad_n, rd_n, wr_n}), 'hF);
        chk("rst_bus_oe", int'(bus_oe), 0);
        chk("rst_bus_out", int'(bus_out), 0);
        reset = 1'b1;
        @(negedge clk);

        // Single write by requester 1
        addr1 = 8'h21; wdata1 = 8'h05; we = 3'b010;
        push(3'b010, 8'h21, 1'b1, 8'h05, 1'b0);
        req = 3'b010;
        wait_done("t1_write_done");
        req = 3'b000;
        repeat (3) @(negedge clk);

        // Single read by requester 2
        addr2 = 8'h22; we = 3'b000; bus_in = 8'h59;
        push(3'b100, 8'h22, 1'b0, 8'h59, 1'b0);
        req = 3'b100;
        wait_done("t2_read_done");
        req = 3'b000;
        repeat (3) @(negedge clk);
        chk("rdata_hold", int'(rdata), 'h59);

        // Contention: all three held, order 0,1,2,0,1,2
        addr0 = 8'h20; wdata0 = 8'hA0;
        addr1 = 8'h21; wdata1 = 8'hB1;
        addr2 = 8'h22; wdata2 = 8'hC2;
        we = 3'b101; bus_in = 8'h3C;
        push(3'b001, 8'h20, 1'b1, 8'hA0, 1'b0);
        push(3'b010, 8'h21, 1'b0, 8'h3C, 1'b1);
        push(3'b100, 8'h22, 1'b1, 8'hC2, 1'b1);
        push(3'b001, 8'h20, 1'b1, 8'hA0, 1'b1);
        push(3'b010, 8'h21, 1'b0, 8'h3C, 1'b1);
        push(3'b100, 8'h22, 1'b1, 8'hC2, 1'b1);
        req = 3'b111;
        for (int k = 0; k < 6; k++) wait_done("t3_contention_done");
        req = 3'b000;
        repeat (3) @(negedge clk);

        // Reset on the third DATA cycle of a write, req[1] left pending
        addr1 = 8'h21; wdata1 = 8'h77; we = 3'b010;
        req = 3'b010;
        n = 0;
        for (int i = 0; i < 200 && n < 3; i++) begin
            @(negedge clk);
            if (!cs_n && ad_n && !wr_n) n++;
        end
        chk("t4_reach_data3", n, 3);
        reset = 1'b0;
        #1;
        chk("t4_strobes", int'({cs_n, ad_n, rd_n, wr_n}), 'hF);
        chk("t4_bus_oe", int'(bus_oe), 0);
        chk("t4_grant", int'(grant), 0);
        chk("t4_done", int'(done), 0);
        chk("t4_rdata", int'(rdata), 0);
        chk("t4_bus_out", int'(bus_out), 0);
        push(3'b010, 8'h21, 1'b1, 8'h77, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        wait_done("t4_after_reset_done");
        req = 3'b000;
        repeat (3) @(negedge clk);

        // Address and request change during GAP are ignored
        addr0 = 8'h20; wdata0 = 8'h11; we = 3'b001;
        push(3'b001, 8'h20, 1'b1, 8'h11, 1'b0);
        req = 3'b001;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (grant != 3'b000 && !cs_n && ad_n && rd_n && wr_n) found = 1'b1;
        end
        chk("t5_reach_gap", int'(found), 1);
        addr0 = 8'h2F; req = 3'b000;
        wait_done("t5_done");
        repeat (30) @(negedge clk);

        chk("queue_empty", q.size(), 0);
        chk("protocol_violations", viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got time limit, required finish");
        $fatal(1, "watchdog");
    end

endmodule
